// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and EX operand forwarding source codes.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MA  = 2'd1,
        FWD_WB  = 2'd2,
        FWD_WBD = 2'd3
    } fwd_src;

    // True when two or more of the hit flags are set at once.
    function automatic logic multi_hit(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fwd_mux4.sv
// Priority encoder plus 4:1 mux selecting one EX operand; youngest producer wins.
module fwd_mux4
    import cpu_pkg::*;
(
    input  logic            hit_idex,
    input  logic            hit_idma,
    input  logic            hit_idwb,
    input  logic            nohit,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] ma_data,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wbd_data,
    output logic [XLEN-1:0] data,
    output logic            multi
);

    fwd_src sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (hit_idex)      sel = FWD_MA;
        else if (hit_idma) sel = FWD_WB;
        else if (hit_idwb) sel = FWD_WBD;
        else if (nohit)    sel = FWD_RF;
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_MA:  data = ma_data;
            FWD_WB:  data = wb_data;
            FWD_WBD: data = wbd_data;
            default: data = rf_data;
        endcase
    end

    assign multi = multi_hit(hit_idex, hit_idma, hit_idwb);

endmodule

// File: rtl/ex_operand_fwd.sv
// EX-stage operand forwarding: selects rs1/rs2 operands and registers store data for MA.
module ex_operand_fwd
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hit_rs1_idex_ex,
    input  logic            hit_rs1_idma_ex,
    input  logic            hit_rs1_idwb_ex,
    input  logic            nohit_rs1_ex,
    input  logic            hit_rs2_idex_ex,
    input  logic            hit_rs2_idma_ex,
    input  logic            hit_rs2_idwb_ex,
    input  logic            nohit_rs2_ex,
    input  logic            stall_ld_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [XLEN-1:0] rd_data_ma,
    input  logic [XLEN-1:0] rd_data_wb,
    input  logic            wbk_rd_reg_wb,
    input  logic            stall,
    input  logic            rst_pipe,
    output logic [XLEN-1:0] rs1_fwd_ex,
    output logic [XLEN-1:0] rs2_fwd_ex,
    output logic [XLEN-1:0] st_data_ma,
    output logic            fwd_sel_err
);

    logic [XLEN-1:0] wb_dly_data;
    logic            multi_rs1;
    logic            multi_rs2;

    fwd_mux4 u_rs1_mux (
        .hit_idex (hit_rs1_idex_ex),
        .hit_idma (hit_rs1_idma_ex),
        .hit_idwb (hit_rs1_idwb_ex),
        .nohit    (nohit_rs1_ex),
        .rf_data  (rs1_data_ex),
        .ma_data  (rd_data_ma),
        .wb_data  (rd_data_wb),
        .wbd_data (wb_dly_data),
        .data     (rs1_fwd_ex),
        .multi    (multi_rs1)
    );

    fwd_mux4 u_rs2_mux (
        .hit_idex (hit_rs2_idex_ex),
        .hit_idma (hit_rs2_idma_ex),
        .hit_idwb (hit_rs2_idwb_ex),
        .nohit    (nohit_rs2_ex),
        .rf_data  (rs2_data_ex),
        .ma_data  (rd_data_ma),
        .wb_data  (rd_data_wb),
        .wbd_data (wb_dly_data),
        .data     (rs2_fwd_ex),
        .multi    (multi_rs2)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_dly_data <= '0;
            st_data_ma  <= '0;
            fwd_sel_err <= 1'b0;
        end else begin
            // Delayed write-back copy covers a register file without write-through.
            if (wbk_rd_reg_wb && !stall)
                wb_dly_data <= rd_data_wb;

            if (rst_pipe)
                st_data_ma <= '0;
            else if (!stall)
                st_data_ma <= stall_ld_ex ? '0 : rs2_fwd_ex;

            if (!stall && !stall_ld_ex && (multi_rs1 || multi_rs2))
                fwd_sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Self-checking bench for ex_operand_fwd: reference model plus a store-data scoreboard queue.
module tb_ex_operand_fwd;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex;
    logic         hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex;
    logic         stall_ld_ex, wbk_rd_reg_wb, stall, rst_pipe;
    logic [W-1:0] rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb;
    logic [W-1:0] rs1_fwd_ex, rs2_fwd_ex, st_data_ma;
    logic         fwd_sel_err;

    ex_operand_fwd dut (
        .clk             (clk),
        .rst             (rst),
        .hit_rs1_idex_ex (hit_rs1_idex_ex),
        .hit_rs1_idma_ex (hit_rs1_idma_ex),
        .hit_rs1_idwb_ex (hit_rs1_idwb_ex),
        .nohit_rs1_ex    (nohit_rs1_ex),
        .hit_rs2_idex_ex (hit_rs2_idex_ex),
        .hit_rs2_idma_ex (hit_rs2_idma_ex),
        .hit_rs2_idwb_ex (hit_rs2_idwb_ex),
        .nohit_rs2_ex    (nohit_rs2_ex),
        .stall_ld_ex     (stall_ld_ex),
        .rs1_data_ex     (rs1_data_ex),
        .rs2_data_ex     (rs2_data_ex),
        .rd_data_ma      (rd_data_ma),
        .rd_data_wb      (rd_data_wb),
        .wbk_rd_reg_wb   (wbk_rd_reg_wb),
        .stall           (stall),
        .rst_pipe        (rst_pipe),
        .rs1_fwd_ex      (rs1_fwd_ex),
        .rs2_fwd_ex      (rs2_fwd_ex),
        .st_data_ma      (st_data_ma),
        .fwd_sel_err     (fwd_sel_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_wbd;
    logic [W-1:0] m_st;
    logic         m_err;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] ref_fwd(input logic idex, input logic idma, input logic idwb,
                                             input logic [W-1:0] rf);
        if (idex)      return rd_data_ma;
        else if (idma) return rd_data_wb;
        else if (idwb) return m_wbd;
        else           return rf;
    endfunction

    function automatic logic two_or_more(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, "_rs1"}, rs1_fwd_ex,
              ref_fwd(hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, rs1_data_ex));
        check({tag, "_rs2"}, rs2_fwd_ex,
              ref_fwd(hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, rs2_data_ex));
    endtask

    // One clock: check combinational outputs, predict the registers, clock, then compare.
    task automatic step(input string tag);
        logic [W-1:0] rs2f;
        logic [W-1:0] got;
        #1;
        check_comb(tag);
        rs2f = ref_fwd(hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, rs2_data_ex);
        if (rst_pipe)         m_st = '0;
        else if (!stall)      m_st = stall_ld_ex ? '0 : rs2f;
        if (!stall && !stall_ld_ex &&
            (two_or_more(hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex) ||
             two_or_more(hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex)))
            m_err = 1'b1;
        if (wbk_rd_reg_wb && !stall) m_wbd = rd_data_wb;
        exp_q.push_back(m_st);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_st"}, st_data_ma, got);
        end
        check({tag, "_err"}, {31'd0, fwd_sel_err}, {31'd0, m_err});
    endtask

    task automatic clear_flags();
        {hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex} = 4'b0;
        {hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex} = 4'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_flags();
        {stall_ld_ex, wbk_rd_reg_wb, stall, rst_pipe} = 4'b0;
        rs1_data_ex = 32'h11; rs2_data_ex = 32'h22;
        rd_data_ma = '0; rd_data_wb = '0;
        m_wbd = '0; m_st = '0; m_err = 1'b0;
        #12;
        check("reset_rs1", rs1_fwd_ex, 32'h11);
        check("reset_st", st_data_ma, 32'h0);
        check("reset_err", {31'd0, fwd_sel_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Forward from MA on rs1 only.
        hit_rs1_idex_ex = 1'b1; rd_data_ma = 32'hAAAA_0001;
        #1;
        check("idex_rs1", rs1_fwd_ex, 32'hAAAA_0001);
        check("idex_rs2_unaffected", rs2_fwd_ex, 32'h22);
        step("idex");

        // Write back 0x5A, then pick it up through the delayed copy.
        clear_flags();
        wbk_rd_reg_wb = 1'b1; rd_data_wb = 32'h5A;
        step("wb_load");
        wbk_rd_reg_wb = 1'b0; rd_data_wb = 32'h77;
        hit_rs2_idwb_ex = 1'b1; rs2_data_ex = 32'h33;
        #1;
        check("idwb_rs2", rs2_fwd_ex, 32'h5A);
        step("idwb");
        check("idwb_st", st_data_ma, 32'h5A);

        // Multiple hits: youngest producer wins and the error flag sticks.
        clear_flags();
        hit_rs1_idex_ex = 1'b1; hit_rs1_idma_ex = 1'b1;
        rd_data_ma = 32'h1; rd_data_wb = 32'h2;
        #1;
        check("multi_rs1", rs1_fwd_ex, 32'h1);
        step("multi");
        check("multi_err", {31'd0, fwd_sel_err}, 32'd1);
        clear_flags();
        step("sticky");
        check("sticky_err", {31'd0, fwd_sel_err}, 32'd1);

        // Stall holds every register even with a write-back pending.
        hit_rs2_idwb_ex = 1'b1; hit_rs1_idex_ex = 1'b1; rd_data_ma = 32'h1234;
        step("pre_stall");
        stall = 1'b1; wbk_rd_reg_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_data_wb = 32'h99 + 32'(i);
            rs2_data_ex = 32'hF0 + 32'(i);
            step("stall");
        end
        check("stall_wbd_hold", rs2_fwd_ex, 32'h5A);
        rst_pipe = 1'b1;
        step("stall_flush");
        check("flush_st", st_data_ma, 32'h0);
        rst_pipe = 1'b0; stall = 1'b0; rd_data_wb = 32'h99;
        step("wb_99");
        wbk_rd_reg_wb = 1'b0;
        #1;
        check("wbd_lag", rs2_fwd_ex, 32'h99);

        // Load-use: bubble, then consumer forwarded from WB.
        clear_flags();
        stall_ld_ex = 1'b1; hit_rs2_idex_ex = 1'b1; rd_data_ma = 32'hBAD0_BAD0;
        step("ld_bubble");
        check("ld_bubble_st", st_data_ma, 32'h0);
        stall_ld_ex = 1'b0; clear_flags();
        hit_rs2_idma_ex = 1'b1; rd_data_wb = 32'hCAFE; rs2_data_ex = 32'hDEAD;
        wbk_rd_reg_wb = 1'b1;
        #1;
        check("ld_use_rs2", rs2_fwd_ex, 32'hCAFE);
        step("ld_use");
        check("ld_use_st", st_data_ma, 32'hCAFE);

        // Asynchronous reset between clock edges.
        clear_flags();
        hit_rs2_idwb_ex = 1'b1; rs2_data_ex = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        m_wbd = '0; m_st = '0; m_err = 1'b0;
        check("arst_st", st_data_ma, 32'h0);
        check("arst_err", {31'd0, fwd_sel_err}, 32'd0);
        check("arst_wbd", rs2_fwd_ex, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            {hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex} = 4'($urandom_range(0, 15));
            {hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex} = 4'($urandom_range(0, 15));
            stall       = ($urandom_range(0, 5) == 0);
            stall_ld_ex = ($urandom_range(0, 5) == 0);
            rst_pipe    = ($urandom_range(0, 7) == 0);
            wbk_rd_reg_wb = 1'($urandom_range(0, 1));
            rs1_data_ex = $urandom; rs2_data_ex = $urandom;
            rd_data_ma  = $urandom; rd_data_wb  = $urandom;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_fwd.md
# ex_operand_fwd

EX-stage operand forwarding datapath, directly downstream of the forwarding hazard detector. It consumes the registered hit/nohit flags for rs1 and rs2 and selects each EX operand from four sources: the register-file read value, the MA-stage result, the WB-stage result, or a one-deep delayed copy of the last write-back. It also registers the forwarded rs2 value as store data for the MA stage. Both operands feed the ALU, branch compare and address generation.

## Interface
- XLEN, 32: operand/data width.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex  input  1 each  rs1 forwarding flags, registered at ID→EX.
- hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex  input  1 each  same flags for rs2.
- stall_ld_ex  input  1  the EX slot is a load-use bubble.
- rs1_data_ex, rs2_data_ex  input  XLEN  register-file values latched into EX.
- rd_data_ma  input  XLEN  result of the instruction now in MA; for loads, the loaded data.
- rd_data_wb  input  XLEN  value being written to the register file this cycle.
- wbk_rd_reg_wb  input  1  write-back enable for rd_data_wb.
- stall  input  1  global pipeline stall.
- rst_pipe  input  1  synchronous pipeline flush.
- rs1_fwd_ex, rs2_fwd_ex  output  XLEN  selected operands (combinational).
- st_data_ma  output  XLEN  registered rs2_fwd_ex for stores.
- fwd_sel_err  output  1  registered: an operand received more than one hit flag in a valid cycle.

## Operation
- Source mapping, by flag set at ID time:
  - idex: the producer is in MA at EX time, so the operand is rd_data_ma.
  - idma: the producer is in WB, so the operand is rd_data_wb.
  - idwb: the producer has retired, so the operand is wb_dly_data.
  - nohit, or no flag set: the operand is rs*_data_ex.
- Priority, highest first: idex, idma, idwb, register file. This covers multiple simultaneous flags, where the youngest producer wins.
- wb_dly_data is an internal XLEN register. It loads rd_data_wb when wbk_rd_reg_wb & ~stall, and holds otherwise. It covers register files without write-through.
- st_data_ma loads rs2_fwd_ex when ~stall. When stall_ld_ex=1 it loads 0 instead (the slot is a bubble).
- fwd_sel_err is set when ~stall & ~stall_ld_ex and two or more of an operand's idex/idma/idwb flags are 1. It is sticky until rst. It is a debug aid only and does not affect selection.
- rst_pipe clears st_data_ma only; wb_dly_data keeps architectural history. stall has priority below rst_pipe.

## Timing
- rs*_fwd_ex: zero-cycle combinational path from flags and data.
- st_data_ma: 1-cycle latency from EX.
- wb_dly_data lags rd_data_wb by exactly one non-stalled cycle.
- Reset values: st_data_ma=0, wb_dly_data=0, fwd_sel_err=0.
  - With all flags at reset value 0, rs*_fwd_ex equals rs*_data_ex.
- During stall, all registers hold and outputs stay stable if inputs are stable.
- Same-cycle rst_pipe and stall: rst_pipe wins and st_data_ma is cleared.
- Reset asserted mid-operation clears all registers immediately. It does not wait for a clock edge.
- Load-use sequence: stall_ld_ex bubble, then the consumer re-enters EX with hit_idma. Data comes from rd_data_wb, never from the load's EX-time value.

## Structure
- Shared package cpu_pkg holds:
  - XLEN;
  - fwd_src enum: FWD_RF, FWD_MA, FWD_WB, FWD_WBD.
- Sub-module fwd_mux4 (priority encoder plus 4:1 mux, width XLEN) is instantiated twice, once for rs1 and once for rs2.
- Top level holds wb_dly_data, st_data_ma and fwd_sel_err.

## Test plan
- Reset, then flags 0, rs1_data_ex=0x11 → rs1_fwd_ex=0x11; st_data_ma=0; fwd_sel_err=0.
- hit_rs1_idex_ex=1, rd_data_ma=0xAAAA0001 → rs1_fwd_ex=0xAAAA0001; rs2 unaffected.
- wbk_rd_reg_wb=1, rd_data_wb=0x5A, one clock; then hit_rs2_idwb_ex=1 → rs2_fwd_ex=0x5A and st_data_ma=0x5A one cycle later.
- hit_rs1_idex_ex=1 and hit_rs1_idma_ex=1, rd_data_ma=0x1, rd_data_wb=0x2 → rs1_fwd_ex=0x1; fwd_sel_err=1 next cycle and sticky.
- stall=1 for 3 cycles with rd_data_wb changing to 0x99 and wbk_rd_reg_wb=1 → wb_dly_data and st_data_ma unchanged. rst_pipe during the stall → st_data_ma=0.
- Load-use: stall_ld_ex=1 → st_data_ma=0. Next cycle hit_rs2_idma_ex=1, rd_data_wb=0xCAFE → rs2_fwd_ex=0xCAFE. Assert rst mid-sequence → all registers 0 asynchronously.
